// File: rtl/shutdown_seq_pkg.sv
// Shared types and defaults for the staged safe-off sequencer.
package shutdown_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_RUN       = 3'd0,
        SEQ_DERATE    = 3'd1,
        SEQ_GATE_OFF  = 3'd2,
        SEQ_LOAD_OFF  = 3'd3,
        SEQ_DISCHARGE = 3'd4,
        SEQ_LOCKOUT   = 3'd5,
        SEQ_RESTART   = 3'd6
    } seq_state_t;

    localparam int DEF_DISCH_CYC   = 16;
    localparam int DEF_LOCKOUT_CYC = 64;
    localparam int DEF_RESTART_CYC = 32;
    localparam int DEF_CNT_W       = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Shared cycle timer: clear restarts at zero, counts while enabled, saturates at limit.
module seq_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] count;

    assign expired = (count >= limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/shutdown_sequencer.sv
// Staged safe-off sequencer driving the power stage from fault detector flags.
// Optional SHDN_TIMESTAMP_EN adds a free-running cycle counter and last_fault_ts.
module shutdown_sequencer
    import shutdown_seq_pkg::*;
#(
    parameter int DISCH_CYC   = DEF_DISCH_CYC,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int RESTART_CYC = DEF_RESTART_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   warning,
    input  logic                   fault,
    input  logic                   shutdown,
    input  logic                   clear_req,
    input  logic                   pwr_good,
    output logic                   gate_en,
    output logic                   load_en,
    output logic                   derate,
    output logic                   bus_discharge,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [CNT_W-1:0]       fault_count
`ifdef SHDN_TIMESTAMP_EN
    ,
    output logic [31:0]            last_fault_ts
`endif
);

    localparam int TW = $clog2(max3(DISCH_CYC, LOCKOUT_CYC, RESTART_CYC)) + 1;

    localparam logic [SEQ_STATE_W-1:0] ST_RUN       = SEQ_RUN;
    localparam logic [SEQ_STATE_W-1:0] ST_DERATE    = SEQ_DERATE;
    localparam logic [SEQ_STATE_W-1:0] ST_GATE_OFF  = SEQ_GATE_OFF;
    localparam logic [SEQ_STATE_W-1:0] ST_LOAD_OFF  = SEQ_LOAD_OFF;
    localparam logic [SEQ_STATE_W-1:0] ST_DISCHARGE = SEQ_DISCHARGE;
    localparam logic [SEQ_STATE_W-1:0] ST_LOCKOUT   = SEQ_LOCKOUT;
    localparam logic [SEQ_STATE_W-1:0] ST_RESTART   = SEQ_RESTART;

    localparam logic [TW-1:0] DISCH_LIM   = TW'(DISCH_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LIM = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] RESTART_LIM = TW'(RESTART_CYC - 1);

    logic [SEQ_STATE_W-1:0] state;
    logic [SEQ_STATE_W-1:0] next_state;
    logic                   trip;
    logic                   gate_entry;
    logic                   timer_clear;
    logic                   timer_en;
    logic                   timer_expired;
    logic [TW-1:0]          timer_limit;

    assign trip       = fault | shutdown;
    assign seq_state  = state;
    assign gate_entry = (next_state == ST_GATE_OFF) && (state != ST_GATE_OFF);

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:       if (trip) next_state = ST_GATE_OFF;
                          else if (warning) next_state = ST_DERATE;
            ST_DERATE:    if (trip) next_state = ST_GATE_OFF;
                          else if (!warning) next_state = ST_RUN;
            ST_GATE_OFF:  next_state = ST_LOAD_OFF;
            ST_LOAD_OFF:  next_state = ST_DISCHARGE;
            ST_DISCHARGE: if (timer_expired) next_state = ST_LOCKOUT;
            // A trip here only holds off the re-arm; the safe-off already happened.
            ST_LOCKOUT:   if (timer_expired && clear_req && !trip) next_state = ST_RESTART;
            ST_RESTART:   if (trip) next_state = ST_GATE_OFF;
                          else if (pwr_good && timer_expired) next_state = ST_RUN;
            default:      next_state = ST_GATE_OFF;
        endcase
    end

    // Soft-start needs consecutive good cycles, so a pwr_good dropout rewinds the timer.
    always_comb begin
        timer_limit = RESTART_LIM;
        timer_en    = 1'b0;
        timer_clear = (next_state != state);
        case (state)
            ST_DISCHARGE: begin timer_limit = DISCH_LIM;   timer_en = 1'b1; end
            ST_LOCKOUT:   begin timer_limit = LOCKOUT_LIM; timer_en = 1'b1; end
            ST_RESTART:   begin
                timer_en = pwr_good;
                if (!pwr_good) timer_clear = 1'b1;
            end
            default: ;
        endcase
    end

    seq_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .en      (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            gate_en       <= 1'b1;
            load_en       <= 1'b1;
            derate        <= 1'b0;
            bus_discharge <= 1'b0;
            fault_count   <= '0;
        end else begin
            state         <= next_state;
            gate_en       <= (next_state == ST_RUN) || (next_state == ST_DERATE);
            load_en       <= (next_state == ST_RUN) || (next_state == ST_DERATE) ||
                             (next_state == ST_GATE_OFF) || (next_state == ST_RESTART);
            derate        <= (next_state == ST_DERATE);
            bus_discharge <= (next_state == ST_DISCHARGE);
            if (gate_entry && (fault_count != {CNT_W{1'b1}})) begin
                fault_count <= fault_count + CNT_W'(1);
            end
        end
    end

`ifdef SHDN_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt     <= '0;
            last_fault_ts <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (gate_entry) last_fault_ts <= cycle_cnt;
        end
    end
`endif

endmodule
